lfsr_burst_arbiter: RTL

LFSR_BURST_ARBITER -- requirements
Module: lfsr_burst_arbiter

---
 rtl/lfsr_burst_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lfsr_burst_arbiter.sv
// lfsr_burst_arbiter
//   Round-robin arbiter that hands out bursts of pseudo-random words.
//   A WIDTH-bit state S feeds POLY chained Galois LFSR steps, so one state
//   advance yields POLY consecutive words; pointer P selects the current one.
//   Ports:
//     clk, reset                 clock, async active-high reset
//     req_valid/req_len          per-requester burst request, length-1
//     req_ready                  one-hot grant pulse (IDLE only)
//     seed_valid/data/ready      reseed handshake (IDLE only, beats requests)
//     out_valid/ready/data/id/last  burst output stream

// Single Galois LFSR step: shift right, fold taps in when the LSB falls out.
module lfsr_step #(
    parameter int                 WIDTH = 32,
    parameter logic [WIDTH-1:0]   TAPS  = 'h80200003
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    assign dout = {1'b0, din[WIDTH-1:1]} ^ (din[0] ? TAPS : '0);
endmodule

module lfsr_burst_arbiter #(
    parameter int               WIDTH = 32,
    parameter int               POLY  = 8,
    parameter int               NREQ  = 4,
    parameter int               LEN_W = 8,
    parameter logic [WIDTH-1:0] TAPS  = 'h80200003,
    localparam int              ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int              PTR_W = (POLY > 1) ? $clog2(POLY) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0][LEN_W-1:0]  req_len,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        seed_valid,
    input  logic [WIDTH-1:0]            seed_data,
    output logic                        seed_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [ID_W-1:0]             out_id,
    output logic                        out_last
);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [PTR_W-1:0]   p_q, p_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    // w[0] is the state itself, w[POLY] is the next state after a full pass.
    logic [POLY:0][WIDTH-1:0] w;
    assign w[0] = s_q;

    for (genvar i = 0; i < POLY; i++) begin : g_step
        lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
            .din  (w[i]),
            .dout (w[i+1])
        );
    end

    // Round-robin pick: first valid requester at or after rr_q, wrapping.
    logic            gnt_any;
    logic [ID_W-1:0] gnt_idx;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        p_d        = p_q;
        rr_d       = rr_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        seed_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (seed_valid) begin
                    seed_ready = 1'b1;
                    // Zero is the LFSR lock-up state; substitute all-ones.
                    s_d = (seed_data == '0) ? '1 : seed_data;
                    p_d = '0;
                end else if (gnt_any) begin
                    req_ready[gnt_idx] = 1'b1;
                    id_d    = gnt_idx;
                    cnt_d   = req_len[gnt_idx];
                    rr_d    = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (p_q == PTR_W'(POLY - 1)) begin
                        s_d = w[POLY];
                        p_d = '0;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '1;
            p_q     <= '0;
            rr_q    <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            p_q     <= p_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == STREAM);
    assign out_data  = w[p_q];
    assign out_id    = id_q;
    assign out_last  = (state_q == STREAM) && (cnt_q == '0);

endmodule
